// File: rtl/pdm_decimator_pkg.sv
// Shared definitions for the PDM-to-PCM CIC decimator.
// Holds parameter limits, internal width derivation and output scaling.
// Pure package: no logic, no latency, no flow control.
package pdm_decimator_pkg;

  localparam int STAGES_MIN = 1;
  localparam int STAGES_MAX = 6;
  localparam int WARM_BITS  = 3;
  localparam int SCALE_BITS = 128;

  // Internal register width: full CIC bit growth plus one bit so the
  // full-scale value 2^(STAGES*LOG2_DECIM) is representable.
  function automatic int cic_width(input int stages, input int log2_decim);
    return stages * log2_decim + 1;
  endfunction

  // Final comb value c lies in 0..2^(w-1). The top bit is set only at exact
  // full scale, which saturates to all ones; otherwise keep the ob bits
  // just below the top bit (plain truncation).
  function automatic logic [SCALE_BITS-1:0] sat_trunc(
    input logic [SCALE_BITS-1:0] c,
    input int                    w,
    input int                    ob
  );
    logic [SCALE_BITS-1:0] mask;
    mask = (SCALE_BITS'(1) << ob) - SCALE_BITS'(1);
    if (((c >> (w - 1)) & SCALE_BITS'(1)) != '0) begin
      return mask;
    end
    return (c >> (w - 1 - ob)) & mask;
  endfunction

endpackage

// File: rtl/pdm_decimator_comb.sv
// One CIC comb stage: out = in - previous in, delay updated on advance.
// Latency: one cycle from i_adv to o_vld.
// No backpressure: o_vld simply follows i_adv one cycle later.
module cic_comb_stage #(
  parameter int W = 25
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_adv,
  input  logic [W-1:0] i_dat,
  output logic [W-1:0] o_dat,
  output logic         o_vld
);

  logic [W-1:0] r_dly;
  logic [W-1:0] r_out;
  logic         r_vld;

  // Subtract the delayed input and remember the new one, only when this stage advances.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_dly <= '0;
      r_out <= '0;
      r_vld <= 1'b0;
    end else begin
      r_vld <= i_adv;
      if (i_adv) begin
        r_out <= i_dat - r_dly;
        r_dly <= i_dat;
      end
    end
  end

  assign o_dat = r_out;
  assign o_vld = r_vld;

endmodule

// File: rtl/pdm_decimator.sv
// PDM to unsigned PCM: STAGES-order CIC, integrators at bit rate, combs at bit rate / 2^LOG2_DECIM.
// Latency: dout/dout_valid registered STAGES+1 cycles after the decimation tick edge.
// No backpressure: din consumed on din_en; dout_valid is a one-cycle strobe. Option: PDM_DECIMATOR_WARMUP_EN.
module pdm_decimator
  import pdm_decimator_pkg::*;
#(
  parameter int OUT_BITS   = 16,
  parameter int STAGES     = 4,
  parameter int LOG2_DECIM = 6
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                din,
  input  logic                din_en,
  output logic [OUT_BITS-1:0] dout,
  output logic                dout_valid
);

  localparam int W     = cic_width(STAGES, LOG2_DECIM);
  localparam int DECIM = 1 << LOG2_DECIM;

  if (STAGES < STAGES_MIN || STAGES > STAGES_MAX) begin : g_bad_stages
    $error("pdm_decimator: STAGES out of range");
  end
  if (DECIM < STAGES + 2) begin : g_bad_decim
    $error("pdm_decimator: decimation ratio too small for STAGES");
  end
  if (STAGES * LOG2_DECIM < OUT_BITS || W > SCALE_BITS) begin : g_bad_width
    $error("pdm_decimator: internal width incompatible with OUT_BITS");
  end

  logic [W-1:0]          r_integ [STAGES];
  logic [LOG2_DECIM-1:0] r_cnt;
  logic                  r_tick;
  logic                  w_tick;
  logic [STAGES:0][W-1:0] w_comb_dat;
  logic [STAGES:0]       w_comb_vld;
  logic                  w_warm_done;

  assign w_tick = din_en & (&r_cnt);

  // Integrator cascade; each stage adds the previous stage's registered value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < STAGES; i++) begin
        r_integ[i] <= '0;
      end
    end else if (din_en) begin
      r_integ[0] <= r_integ[0] + W'(din);
      for (int i = 1; i < STAGES; i++) begin
        r_integ[i] <= r_integ[i] + r_integ[i-1];
      end
    end
  end

  // Decimation counter and registered tick that launches the comb pipeline.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt  <= '0;
      r_tick <= 1'b0;
    end else begin
      r_tick <= w_tick;
      if (din_en) begin
        r_cnt <= r_cnt + LOG2_DECIM'(1);
      end
    end
  end

  assign w_comb_dat[0] = r_integ[STAGES-1];
  assign w_comb_vld[0] = r_tick;

  for (genvar k = 0; k < STAGES; k++) begin : g_comb
    cic_comb_stage #(.W(W)) u_comb (
      .clk   (clk),
      .rst   (rst),
      .i_adv (w_comb_vld[k]),
      .i_dat (w_comb_dat[k]),
      .o_dat (w_comb_dat[k+1]),
      .o_vld (w_comb_vld[k+1])
    );
  end

`ifdef PDM_DECIMATOR_WARMUP_EN
  logic [WARM_BITS-1:0] r_warm;

  assign w_warm_done = (r_warm == WARM_BITS'(STAGES + 1));

  // Count filter outputs after reset until the transient has flushed; saturates.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_warm <= '0;
    end else if (w_comb_vld[STAGES] && !w_warm_done) begin
      r_warm <= r_warm + WARM_BITS'(1);
    end
  end
`else
  assign w_warm_done = 1'b1;
`endif

  // Scale the final comb value into the output register and strobe valid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dout       <= '0;
      dout_valid <= 1'b0;
    end else begin
      dout_valid <= w_comb_vld[STAGES] & w_warm_done;
      if (w_comb_vld[STAGES]) begin
        dout <= OUT_BITS'(sat_trunc(SCALE_BITS'(w_comb_dat[STAGES]), W, OUT_BITS));
      end
    end
  end

endmodule

// File: tb/tb_pdm_decimator.sv
// Self-checking bench for pdm_decimator against a convolution-based CIC model.
// Model: output = sum of CIC impulse response (boxcar^STAGES) times strobed input bits.
// Timing and warmup suppression are predicted from tick positions in strobe count.
module tb_pdm_decimator;

  localparam int OUT_BITS   = 16;
  localparam int STAGES     = 4;
  localparam int LOG2_DECIM = 6;
  localparam int DECIM      = 1 << LOG2_DECIM;
  localparam int W          = STAGES * LOG2_DECIM + 1;
  localparam int LAG        = STAGES - 1;

  logic                clk = 1'b0;
  logic                rst;
  logic                din;
  logic                din_en;
  logic [OUT_BITS-1:0] dout;
  logic                dout_valid;

  always #5 clk = ~clk;

  pdm_decimator #(
    .OUT_BITS   (OUT_BITS),
    .STAGES     (STAGES),
    .LOG2_DECIM (LOG2_DECIM)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .din        (din),
    .din_en     (din_en),
    .dout       (dout),
    .dout_valid (dout_valid)
  );

  typedef struct {
    int                  due;
    logic [OUT_BITS-1:0] val;
    bit                  show;
  } exp_t;

  int checks = 0;
  int errors = 0;

  longint              h[];
  bit                  xs[$];
  exp_t                pend[$];
  int                  edge_no = 0;
  int                  nstrobe = 0;
  int                  nout    = 0;
  int                  npulse  = 0;
  logic [OUT_BITS-1:0] exp_dout = '0;
  logic [OUT_BITS-1:0] first_dout = '0;
  logic [OUT_BITS-1:0] last_dout = '0;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, obs, exp, edge_no);
    end
  endtask

  // CIC output for the tick at the current strobe count.
  function automatic logic [OUT_BITS-1:0] model_out();
    longint c = 0;
    for (int j = 0; j < h.size(); j++) begin
      int k = nstrobe - LAG - j;
      if (k >= 1 && xs[k-1]) c += h[j];
    end
    if (c >= (longint'(1) << (W - 1))) return '1;
    return OUT_BITS'(c >> (W - 1 - OUT_BITS));
  endfunction

  task automatic step(input bit d, input bit en);
    exp_t e;
    din    = d;
    din_en = en;
    @(posedge clk);
    edge_no++;
    if (en) begin
      xs.push_back(d);
      nstrobe++;
      if (nstrobe % DECIM == 0) begin
        e.due = edge_no + STAGES + 1;
        e.val = model_out();
`ifdef PDM_DECIMATOR_WARMUP_EN
        e.show = (nout >= STAGES + 1);
`else
        e.show = 1'b1;
`endif
        pend.push_back(e);
        nout++;
      end
    end
    #1;
    if (pend.size() > 0 && pend[0].due == edge_no) begin
      e = pend.pop_front();
      check_val("dout_valid", dout_valid, e.show);
      check_val("dout", dout, e.val);
      exp_dout  = e.val;
      npulse++;
      if (npulse == 1) first_dout = dout;
      last_dout = dout;
    end else begin
      check_val("dout_valid_idle", dout_valid, 0);
      check_val("dout_hold", dout, exp_dout);
    end
  endtask

  task automatic flush();
    repeat (STAGES + 2) step(1'b0, 1'b0);
  endtask

  task automatic apply_reset();
    rst    = 1'b1;
    din    = 1'b0;
    din_en = 1'b0;
    #1;
    check_val("rst_dout", dout, 0);
    check_val("rst_valid", dout_valid, 0);
    repeat (2) begin
      @(posedge clk);
      edge_no++;
    end
    #1;
    rst = 1'b0;
    xs.delete();
    pend.delete();
    nstrobe  = 0;
    nout     = 0;
    npulse   = 0;
    exp_dout = '0;
  endtask

  initial begin
    longint tmp[];
    bit     found;

    // Impulse response: STAGES-fold convolution of a DECIM-long boxcar.
    h = new[1];
    h[0] = 1;
    for (int s = 0; s < STAGES; s++) begin
      tmp = new[h.size() + DECIM - 1];
      foreach (tmp[i]) tmp[i] = 0;
      for (int i = 0; i < h.size(); i++)
        for (int j = 0; j < DECIM; j++) tmp[i+j] += h[i];
      h = tmp;
    end

    rst = 1'b1;
    din = 1'b0;
    din_en = 1'b0;
    apply_reset();

    // All ones: starts with transients, settles to full scale.
    for (int i = 0; i < DECIM * 8; i++) step(1'b1, 1'b1);
    flush();
    check_val("first_is_transient", first_dout < 16'hFFFF, 1);
    check_val("ones_settled", last_dout, 16'hFFFF);

    // All zeros.
    for (int i = 0; i < DECIM * 8; i++) step(1'b0, 1'b1);
    flush();
    check_val("zeros_settled", last_dout, 16'h0000);

    // Half density.
    for (int i = 0; i < DECIM * 8; i++) step(bit'(i % 2 == 0), 1'b1);
    flush();
    check_val("half_settled", last_dout, 16'h8000);

    // Quarter density.
    for (int i = 0; i < DECIM * 8; i++) step(bit'(i % 4 == 0), 1'b1);
    flush();
    check_val("quarter_settled", last_dout, 16'h4000);

    // Sparse strobes, every third cycle.
    for (int i = 0; i < DECIM * 3 * 8; i++) step(1'b1, bit'(i % 3 == 0));
    flush();
    check_val("sparse_ones", last_dout, 16'hFFFF);

    // Random bits with random strobe gaps.
    for (int i = 0; i < 2000; i++) step(bit'($urandom_range(1, 0)), bit'($urandom_range(3, 0) != 0));
    flush();

    // Reset two cycles after a tick: that output must never appear.
    apply_reset();
    found = 1'b0;
    for (int i = 0; i < 4 * DECIM && !found; i++) begin
      step(1'b1, 1'b1);
      if (nstrobe > 0 && nstrobe % DECIM == 0) found = 1'b1;
    end
    check_val("found_tick", found, 1);
    step(1'b1, 1'b1);
    step(1'b1, 1'b1);
    apply_reset();
    for (int i = 0; i < DECIM * 7; i++) step(1'b1, 1'b1);
    flush();
    check_val("post_reset_pulses", npulse, 7);
    check_val("post_reset_ones", last_dout, 16'hFFFF);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
